ssd_segment_decoder: RTL and testbench
======================================

Name: ssd_segment_decoder

Overview:
- Receive-side counterpart of the two-digit PmodSSD driver. It samples the multiplexed anode-select and 7-segment cathode lines (gcbafed order) and decodes each pattern back to its 4-bit code.
- Each digit position is filtered for stability before it is committed. The block then presents digit_one/digit_two with per-digit enables, which are the same signals the display driver consumes.
- Used as an on-board loopback monitor and as the self-check block in display testbenches.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on ssd_anode and ssd_seg before sampling (0 = no synchroniser, for same-domain use).
- STABLE_COUNT, 4, consecutive identical valid samples of one position required to commit it (range 1..15).
- TIMEOUT, 256, cycles without a valid sample of a position before that position is invalidated (range 2..65535).

Ports:
- fast_clk  input  1  sampling clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- ssd_anode  input  1  anode select: 0 = digit one, 1 = digit two.
- ssd_seg  input  7  cathode pattern, bit order gcbafed, 1 = segment lit.
- digit_one  output  4  committed code for position 0.
- digit_two  output  4  committed code for position 1.
- one_en  output  1  digit_one holds a real digit (0-9, A).
- two_en  output  1  digit_two holds a real digit (0-9, A).
- update  output  1  one-cycle pulse when either committed value changes.
- decode_err  output  1  one-cycle pulse per sample with an unrecognised pattern.
- link_ok  output  1  both positions have a valid sample within TIMEOUT.

Behaviour:
- Reset values:
  - digit_one = digit_two = 4'hF.
  - one_en = two_en = 0.
  - update = decode_err = 0.
  - link_ok = 0.
  - Synchroniser flops, candidates and counters cleared.
  - Reset asserted mid-operation aborts all in-progress stability counts immediately.
- Pipeline:
  - SYNC_STAGES sync flops.
  - Then one sample register (anode_s, seg_s).
  - Decode is combinational on the sample register.
  - Candidate, counter and committed outputs are registered on the next edge.
  - update and decode_err are registered, so they appear one cycle after the offending or committing sample.
- Decode table (seg to code):
  - 0111111=0, 0110000=1, 1011011=2, 1111001=3, 1110100=4, 1101101=5, 1101111=6, 0111000=7, 1111111=8, 1111101=9, 1111110=A.
  - 1000000 (dash) = F.
  - Any other pattern, including all-zero, is invalid.
- Per-position state p in {0,1}, selected by anode_s: candidate cand_p[3:0] and counter cnt_p[3:0] (saturating at STABLE_COUNT).
- Sample of position p that decodes to a valid code c:
  - If c == cand_p: cnt_p <= min(cnt_p+1, STABLE_COUNT).
  - Else: cand_p <= c and cnt_p <= 1.
  - The timeout counter for p is reloaded.
- Commit:
  - Occurs when the updated cnt_p equals STABLE_COUNT and c differs from the committed digit_p/en_p state.
  - digit_p <= c; en_p <= (c != F); update pulses.
  - Re-reaching STABLE_COUNT on the same value produces no pulse.
- Invalid sample of position p:
  - decode_err pulses.
  - cnt_p <= 0; cand_p is unchanged.
  - Committed outputs are unchanged.
  - The timeout counter is not reloaded.
- Only the selected position is touched per cycle. Both positions can never commit on the same edge; consecutive edges can each commit, giving two separate update pulses.
- Timeout:
  - Each position has a counter incremented every cycle it receives no valid sample.
  - On reaching TIMEOUT: digit_p <= F, en_p <= 0, cnt_p <= 0.
  - update pulses only if this changed the outputs.
  - The counter then holds at TIMEOUT until the next valid sample.
- link_ok:
  - Equals 1 when both timeout counters are below TIMEOUT and each position has had at least one valid sample since reset.
  - Deasserts on the cycle its timeout fires.
- Anode stuck at one value: the other position times out, and link_ok drops after TIMEOUT cycles.
- Commit latency with a toggling anode and stable data: the first commit for a position appears SYNC_STAGES + 1 + 2*(STABLE_COUNT-1) + 1 cycles after its first sample reaches the pins. With defaults this is 10 cycles for position 0 when that position is sampled first.

Test Plan:
- Reset, then drive the anode toggling each cycle with digit one = 3 (1111001) and digit two = 7 (0111000). Expected: after defaults latency, digit_one=3, one_en=1, digit_two=7, two_en=1, exactly two update pulses, link_ok=1.
- Hold the patterns steady for 200 cycles after commit. Expected: no further update pulses and no decode_err.
- Change digit two to dash (1000000) for 4 samples. Expected: digit_two=F, two_en=0, one update pulse, digit_one unchanged.
- Inject one glitch sample 0000001 on position 0 between stable 5s. Expected: decode_err pulses once, digit_one stays 5, no update, and the recommit count restarts so no spurious pulse follows.
- Hold the anode at 0 for 300 cycles. Expected: at cycle 256 without a position 1 sample, two_en=0, digit_two=F, link_ok=0, one update pulse. Resuming toggling restores two_en after STABLE_COUNT samples.
- Assert reset mid-stream after 2 of 4 matching samples of a new value. Expected: all outputs return to reset values at once. After release, the full STABLE_COUNT of fresh samples is needed before the first commit.

Source files
------------

// File: rtl/ssd_segment_decoder.sv
// Two-digit PmodSSD receive monitor: samples anode/cathode lines,
// debounces each digit position and reports the committed codes.
module ssd_segment_decoder #(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = 4,
  parameter int TIMEOUT      = 256
) (
  input  logic       fast_clk,
  input  logic       reset,
  input  logic       ssd_anode,
  input  logic [6:0] ssd_seg,
  output logic [3:0] digit_one,
  output logic [3:0] digit_two,
  output logic       one_en,
  output logic       two_en,
  output logic       update,
  output logic       decode_err,
  output logic       link_ok
);

  localparam logic [3:0]  SC  = 4'(STABLE_COUNT);
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  logic [7:0] pin_w;
  logic [7:0] sync_w;

  assign pin_w = {ssd_anode, ssd_seg};

  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_w = pin_w;
  end else begin : g_sync
    logic [7:0] sync_q [SYNC_STAGES];

    always_ff @(posedge fast_clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < SYNC_STAGES; i++)
          sync_q[i] <= '0;
      end else begin
        sync_q[0] <= pin_w;
        for (int i = 1; i < SYNC_STAGES; i++)
          sync_q[i] <= sync_q[i-1];
      end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];
  end

  logic       anode_s_q;
  logic [6:0] seg_s_q;

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      anode_s_q <= 1'b0;
      seg_s_q   <= '0;
    end else begin
      anode_s_q <= sync_w[7];
      seg_s_q   <= sync_w[6:0];
    end
  end

  // Segment order gcbafed; dash maps to the blank code F
  logic       dec_vld;
  logic [3:0] dec_code;

  always_comb begin
    dec_vld  = 1'b1;
    dec_code = 4'hF;
    unique case (seg_s_q)
      7'b0111111: dec_code = 4'h0;
      7'b0110000: dec_code = 4'h1;
      7'b1011011: dec_code = 4'h2;
      7'b1111001: dec_code = 4'h3;
      7'b1110100: dec_code = 4'h4;
      7'b1101101: dec_code = 4'h5;
      7'b1101111: dec_code = 4'h6;
      7'b0111000: dec_code = 4'h7;
      7'b1111111: dec_code = 4'h8;
      7'b1111101: dec_code = 4'h9;
      7'b1111110: dec_code = 4'hA;
      7'b1000000: dec_code = 4'hF;
      default:    dec_vld  = 1'b0;
    endcase
  end

  logic [3:0]  cand_q [2];
  logic [3:0]  cand_d [2];
  logic [3:0]  cnt_q  [2];
  logic [3:0]  cnt_d  [2];
  logic [15:0] tmo_q  [2];
  logic [15:0] tmo_d  [2];
  logic        seen_q [2];
  logic        seen_d [2];
  logic [3:0]  dig_q  [2];
  logic [3:0]  dig_d  [2];
  logic        en_q   [2];
  logic        en_d   [2];
  logic        upd_q, upd_d;
  logic        err_q, err_d;

  always_comb begin
    upd_d = 1'b0;
    err_d = 1'b0;
    for (int p = 0; p < 2; p++) begin
      cand_d[p] = cand_q[p];
      cnt_d[p]  = cnt_q[p];
      tmo_d[p]  = tmo_q[p];
      seen_d[p] = seen_q[p];
      dig_d[p]  = dig_q[p];
      en_d[p]   = en_q[p];
      if (anode_s_q == p[0] && dec_vld) begin
        tmo_d[p]  = '0;
        seen_d[p] = 1'b1;
        if (dec_code == cand_q[p]) begin
          cnt_d[p] = (cnt_q[p] >= SC) ? SC : cnt_q[p] + 4'd1;
        end else begin
          cand_d[p] = dec_code;
          cnt_d[p]  = 4'd1;
        end
        if (cnt_d[p] == SC &&
            (dec_code != dig_q[p] ||
             en_q[p] != (dec_code != 4'hF))) begin
          dig_d[p] = dec_code;
          en_d[p]  = (dec_code != 4'hF);
          upd_d    = 1'b1;
        end
      end else begin
        if (anode_s_q == p[0]) begin
          err_d    = 1'b1;
          cnt_d[p] = '0;
        end
        // Counter parks at TIMEOUT so the expiry acts only once
        if (tmo_q[p] < TMO) begin
          tmo_d[p] = tmo_q[p] + 16'd1;
          if (tmo_d[p] == TMO) begin
            cnt_d[p] = '0;
            dig_d[p] = 4'hF;
            en_d[p]  = 1'b0;
            if (dig_q[p] != 4'hF || en_q[p])
              upd_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      upd_q <= 1'b0;
      err_q <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        cand_q[p] <= '0;
        cnt_q[p]  <= '0;
        tmo_q[p]  <= '0;
        seen_q[p] <= 1'b0;
        dig_q[p]  <= 4'hF;
        en_q[p]   <= 1'b0;
      end
    end else begin
      upd_q <= upd_d;
      err_q <= err_d;
      for (int p = 0; p < 2; p++) begin
        cand_q[p] <= cand_d[p];
        cnt_q[p]  <= cnt_d[p];
        tmo_q[p]  <= tmo_d[p];
        seen_q[p] <= seen_d[p];
        dig_q[p]  <= dig_d[p];
        en_q[p]   <= en_d[p];
      end
    end
  end

  assign digit_one  = dig_q[0];
  assign digit_two  = dig_q[1];
  assign one_en     = en_q[0];
  assign two_en     = en_q[1];
  assign update     = upd_q;
  assign decode_err = err_q;
  assign link_ok    = seen_q[0] && seen_q[1] &&
                      (tmo_q[0] < TMO) && (tmo_q[1] < TMO);

endmodule

// File: tb/tb_ssd_segment_decoder.sv
// Bench for ssd_segment_decoder: directed scenarios plus random
// traffic against a sample-level reference model.
module tb_ssd_segment_decoder;

  localparam int SYNC = 2;
  localparam int SC   = 4;
  localparam int TMO  = 256;

  logic       fast_clk = 1'b0;
  logic       reset    = 1'b1;
  logic       ssd_anode = 1'b0;
  logic [6:0] ssd_seg   = '0;
  logic [3:0] digit_one, digit_two;
  logic       one_en, two_en, update, decode_err, link_ok;

  ssd_segment_decoder #(
    .SYNC_STAGES (SYNC),
    .STABLE_COUNT(SC),
    .TIMEOUT     (TMO)
  ) dut (
    .fast_clk  (fast_clk),
    .reset     (reset),
    .ssd_anode (ssd_anode),
    .ssd_seg   (ssd_seg),
    .digit_one (digit_one),
    .digit_two (digit_two),
    .one_en    (one_en),
    .two_en    (two_en),
    .update    (update),
    .decode_err(decode_err),
    .link_ok   (link_ok)
  );

  always #5 fast_clk = ~fast_clk;

  localparam logic [6:0] DASH  = 7'b1000000;
  localparam logic [6:0] GLTCH = 7'b0000001;

  logic [6:0] pat [11] = '{
    7'b0111111, 7'b0110000, 7'b1011011, 7'b1111001,
    7'b1110100, 7'b1101101, 7'b1101111, 7'b0111000,
    7'b1111111, 7'b1111101, 7'b1111110
  };

  int checks = 0;
  int errors = 0;
  int n_upd  = 0;
  int n_err  = 0;
  logic ph = 1'b0;

  // Reference model: per position run length, idle time, committed value
  int m_dig[2], m_en[2], m_cand[2], m_run[2], m_since[2], m_seen[2];
  int m_upd, m_err;
  int         pipe_a[$];
  logic [6:0] pipe_s[$];

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 11; i++)
      if (pat[i] == s) return i;
    if (s == DASH) return 15;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      m_dig[p] = 15; m_en[p] = 0; m_cand[p] = 0;
      m_run[p] = 0; m_since[p] = 0; m_seen[p] = 0;
    end
    m_upd = 0; m_err = 0;
    pipe_a.delete(); pipe_s.delete();
    for (int i = 0; i < SYNC + 1; i++) begin
      pipe_a.push_back(0);
      pipe_s.push_back(7'd0);
    end
  endfunction

  function automatic void model_step();
    int a, c;
    logic [6:0] s;
    pipe_a.push_back(int'(ssd_anode));
    pipe_s.push_back(ssd_seg);
    a = pipe_a.pop_front();
    s = pipe_s.pop_front();
    c = decode(s);
    m_upd = 0; m_err = 0;
    for (int p = 0; p < 2; p++) begin
      if (p == a && c >= 0) begin
        m_since[p] = 0; m_seen[p] = 1;
        if (c == m_cand[p])
          m_run[p] = (m_run[p] + 1 > SC) ? SC : m_run[p] + 1;
        else begin
          m_cand[p] = c; m_run[p] = 1;
        end
        if (m_run[p] == SC &&
            (m_dig[p] != c || m_en[p] != int'(c != 15))) begin
          m_dig[p] = c; m_en[p] = int'(c != 15); m_upd = 1;
        end
      end else begin
        if (p == a) begin
          m_err = 1; m_run[p] = 0;
        end
        if (m_since[p] < TMO) begin
          m_since[p]++;
          if (m_since[p] == TMO) begin
            if (m_dig[p] != 15 || m_en[p] != 0) m_upd = 1;
            m_dig[p] = 15; m_en[p] = 0; m_run[p] = 0;
          end
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [14:0] obs, exp;
    logic        lnk;
    @(posedge fast_clk);
    if (reset) model_reset();
    else       model_step();
    #1;
    lnk = (m_seen[0] != 0) && (m_seen[1] != 0) &&
          (m_since[0] < TMO) && (m_since[1] < TMO);
    obs = {digit_one, digit_two, one_en, two_en,
           update, decode_err, link_ok};
    exp = {m_dig[0][3:0], m_dig[1][3:0], m_en[0][0], m_en[1][0],
           m_upd[0], m_err[0], lnk};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL cycle_model observed=%h expected=%h", obs, exp);
    end
    n_upd += int'(update);
    n_err += int'(decode_err);
  endtask

  task automatic toggle(input logic [6:0] s0, input logic [6:0] s1,
                        input int n);
    for (int i = 0; i < n; i++) begin
      ssd_anode = ph;
      ssd_seg   = ph ? s1 : s0;
      ph        = ~ph;
      tick();
    end
  endtask

  task automatic hold(input logic a, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      ssd_anode = a;
      ssd_seg   = s;
      tick();
    end
  endtask

  function automatic logic [6:0] pick();
    int r;
    r = int'($urandom_range(9));
    if (r < 8)  return pat[$urandom_range(10)];
    if (r == 8) return DASH;
    return 7'($urandom_range(127));
  endfunction

  initial begin
    int u0, e0;
    logic [6:0] cur [2];

    model_reset();
    hold(1'b0, 7'd0, 3);
    chk("reset_outs", {digit_one, digit_two, 4'b0, one_en, two_en,
                       update, decode_err, link_ok, 1'b0},
        {4'hF, 4'hF, 4'b0, 6'b0});

    reset = 1'b0;
    n_upd = 0;
    ph    = 1'b0;
    toggle(pat[3], pat[7], 9);
    chk("lat_before", {15'd0, one_en}, 16'd0);
    toggle(pat[3], pat[7], 1);
    chk("lat_one", {11'd0, one_en, digit_one}, {11'd0, 1'b1, 4'h3});
    toggle(pat[3], pat[7], 1);
    chk("lat_two", {11'd0, two_en, digit_two}, {11'd0, 1'b1, 4'h7});
    chk("first_upd", 16'(n_upd), 16'd2);
    chk("link_up", {15'd0, link_ok}, 16'd1);

    u0 = n_upd; e0 = n_err;
    toggle(pat[3], pat[7], 200);
    chk("steady_upd", 16'(n_upd - u0), 16'd0);
    chk("steady_err", 16'(n_err - e0), 16'd0);

    u0 = n_upd;
    toggle(pat[3], DASH, 12);
    chk("dash_two", {11'd0, two_en, digit_two}, {11'd0, 1'b0, 4'hF});
    chk("dash_upd", 16'(n_upd - u0), 16'd1);
    chk("dash_one", {12'd0, digit_one}, 16'h3);

    toggle(pat[5], DASH, 16);
    chk("five_one", {12'd0, digit_one}, 16'h5);
    if (ph) toggle(pat[5], DASH, 1);
    u0 = n_upd; e0 = n_err;
    toggle(GLTCH, DASH, 1);
    toggle(pat[5], DASH, 20);
    chk("glitch_err", 16'(n_err - e0), 16'd1);
    chk("glitch_upd", 16'(n_upd - u0), 16'd0);
    chk("glitch_one", {12'd0, digit_one}, 16'h5);

    toggle(pat[5], pat[7], 20);
    chk("seven_two", {12'd0, digit_two}, 16'h7);
    u0 = n_upd;
    hold(1'b0, pat[5], 300);
    chk("tmo_two", {10'd0, two_en, link_ok, digit_two},
        {10'd0, 1'b0, 1'b0, 4'hF});
    chk("tmo_upd", 16'(n_upd - u0), 16'd1);
    chk("tmo_one", {11'd0, one_en, digit_one}, {11'd0, 1'b1, 4'h5});
    ph = 1'b0;
    toggle(pat[5], pat[7], 12);
    chk("resume_two", {10'd0, two_en, link_ok, digit_two},
        {10'd0, 1'b1, 1'b1, 4'h7});

    if (ph) toggle(pat[5], pat[7], 1);
    toggle(pat[8], pat[7], 7);
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_outs", {digit_one, digit_two, 4'b0, one_en, two_en,
                        update, decode_err, link_ok, 1'b0},
        {4'hF, 4'hF, 4'b0, 6'b0});
    hold(1'b0, 7'd0, 2);
    reset = 1'b0;
    ph    = 1'b0;
    toggle(pat[8], pat[7], 9);
    chk("rst_fresh", {15'd0, one_en}, 16'd0);
    toggle(pat[8], pat[7], 1);
    chk("rst_commit", {11'd0, one_en, digit_one}, {11'd0, 1'b1, 4'h8});

    cur[0] = pat[1];
    cur[1] = pat[2];
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < 2; p++)
        if ($urandom_range(7) == 0) cur[p] = pick();
      if ($urandom_range(15) < 12) begin
        ssd_anode = ph;
        ph        = ~ph;
      end else begin
        ssd_anode = 1'($urandom_range(1));
      end
      ssd_seg = cur[ssd_anode];
      if ($urandom_range(31) == 0) ssd_seg = 7'($urandom_range(127));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
